ulbf_master_player: RTL



---
 rtl/ulbf_master_player.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ulbf_master_player.sv
// Replays a block from a dual-port RAM onto an AXI4-Stream master, niter times.
// Port B is a host read/write port; port A feeds a credit-managed FWFT prefetch FIFO.
module ulbf_master_player #(
    parameter int unsigned TDATA_WIDTH      = 64,
    parameter int unsigned TKEEP_WIDTH      = TDATA_WIDTH / 8,
    parameter int unsigned RAM_DEPTH        = 8192,
    parameter int unsigned RAM_READ_LATENCY = 4,
    parameter int unsigned FIFO_DEPTH       = 8
) (
    input  logic                   m_axis_clk,
    input  logic                   master_rst_n,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
    input  logic                   m_axis_tready,
    input  logic                   master_go,
    input  logic [15:0]            block_len,
    input  logic [11:0]            niter,
    output logic                   txdone,
    output logic [3:0]             current_state_wire,
    output logic [15:0]            txram_counter_wire,
    input  logic [TKEEP_WIDTH-1:0] web,
    input  logic                   enb,
    input  logic [15:0]            addrb,
    input  logic [TDATA_WIDTH-1:0] dinb,
    output logic [TDATA_WIDTH-1:0] doutb
);

    localparam int unsigned AW = $clog2(RAM_DEPTH);
    localparam int unsigned L  = RAM_READ_LATENCY;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 2;

    typedef enum logic [3:0] {
        S_IDLE  = 4'h1,
        S_RUN   = 4'h2,
        S_DRAIN = 4'h4,
        S_DONE  = 4'h8
    } state_t;

    state_t            r_state;
    logic [15:0]       r_block_len;
    logic [11:0]       r_niter;
    logic [27:0]       r_total;
    logic [27:0]       r_issue_cnt;
    logic [15:0]       r_rd_addr;
    logic [11:0]       r_frame_cnt;
    logic [15:0]       r_txram_cnt;
    logic              r_txdone;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_fifo_cnt;
    logic [PW-1:0]     r_wp;
    logic [PW-1:0]     r_rp;

    logic [TDATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [TDATA_WIDTH-1:0] r_a_data [L];
    logic [L-1:0]           r_a_vld;
    logic [L-1:0]           r_a_last;
    logic [TDATA_WIDTH-1:0] r_b_data [L];
    logic [TDATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  r_fifo_last;

    logic          w_b_en;
    logic [AW-1:0] w_b_addr;
    logic [AW-1:0] w_a_addr;
    logic          w_credit;
    logic          w_issue;
    logic          w_rd_last;
    logic          w_push;
    logic          w_hs;
    logic          w_final;
    logic          w_go_ok;

    // Out-of-range host addresses are dropped rather than aliased.
    assign w_b_en    = enb && ({1'b0, addrb} < 17'(RAM_DEPTH));
    assign w_b_addr  = addrb[AW-1:0];
    assign w_a_addr  = r_rd_addr[AW-1:0];
    assign w_credit  = (r_inflight + r_fifo_cnt) < CW'(FIFO_DEPTH);
    assign w_issue   = (r_state == S_RUN) && w_credit;
    assign w_rd_last = (r_rd_addr == r_block_len - 16'd1);
    assign w_push    = r_a_vld[L-1];
    assign w_hs      = m_axis_tvalid && m_axis_tready;
    assign w_final   = w_hs && m_axis_tlast && (r_frame_cnt == r_niter - 12'd1)
                       && (r_inflight == '0) && (r_fifo_cnt == CW'(1));
    assign w_go_ok   = master_go && (niter != 12'd0) && (block_len != 16'd0)
                       && ((r_state == S_IDLE) || (r_state == S_DONE));

    assign m_axis_tvalid      = (r_fifo_cnt != '0);
    assign m_axis_tdata       = r_fifo_data[r_rp];
    assign m_axis_tlast       = m_axis_tvalid && r_fifo_last[r_rp];
    assign m_axis_tkeep       = '1;
    assign txdone             = r_txdone;
    assign current_state_wire = r_state;
    assign txram_counter_wire = r_txram_cnt;
    assign doutb              = r_b_data[L-1];

    // RAM array: host byte writes, contents survive reset.
    always_ff @(posedge m_axis_clk) begin
        for (int i = 0; i < int'(TKEEP_WIDTH); i++) begin
            if (w_b_en && web[i]) r_mem[w_b_addr][i*8 +: 8] <= dinb[i*8 +: 8];
        end
    end

    always_ff @(posedge m_axis_clk) begin
        if (w_issue) r_a_data[0] <= r_mem[w_a_addr];
        for (int i = 1; i < int'(L); i++) r_a_data[i] <= r_a_data[i-1];
    end

    always_ff @(posedge m_axis_clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            for (int i = 0; i < int'(L); i++) r_b_data[i] <= '0;
        end else begin
            if (w_b_en) r_b_data[0] <= r_mem[w_b_addr];
            for (int i = 1; i < int'(L); i++) r_b_data[i] <= r_b_data[i-1];
        end
    end

    // Port A tag pipeline, in-flight credit count and prefetch FIFO.
    always_ff @(posedge m_axis_clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_a_vld     <= '0;
            r_a_last    <= '0;
            r_inflight  <= '0;
            r_fifo_cnt  <= '0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_fifo_last <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) r_fifo_data[i] <= '0;
        end else begin
            r_a_vld[0]  <= w_issue;
            r_a_last[0] <= w_rd_last;
            for (int i = 1; i < int'(L); i++) begin
                r_a_vld[i]  <= r_a_vld[i-1];
                r_a_last[i] <= r_a_last[i-1];
            end
            if (w_push) begin
                r_fifo_data[r_wp] <= r_a_data[L-1];
                r_fifo_last[r_wp] <= r_a_last[L-1];
                r_wp <= (r_wp == PW'(FIFO_DEPTH - 1)) ? '0 : r_wp + PW'(1);
            end
            if (w_hs) r_rp <= (r_rp == PW'(FIFO_DEPTH - 1)) ? '0 : r_rp + PW'(1);
            r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_hs);
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
        end
    end

    always_ff @(posedge m_axis_clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_state     <= S_IDLE;
            r_block_len <= '0;
            r_niter     <= '0;
            r_total     <= '0;
            r_issue_cnt <= '0;
            r_rd_addr   <= '0;
            r_frame_cnt <= '0;
            r_txram_cnt <= '0;
            r_txdone    <= 1'b0;
        end else begin
            if (w_hs) begin
                r_txram_cnt <= r_txram_cnt + 16'd1;
                if (m_axis_tlast) r_frame_cnt <= r_frame_cnt + 12'd1;
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go_ok) begin
                        r_block_len <= block_len;
                        r_niter     <= niter;
                        r_total     <= 28'(niter) * 28'(block_len);
                        r_issue_cnt <= '0;
                        r_rd_addr   <= '0;
                        r_frame_cnt <= '0;
                        r_txram_cnt <= '0;
                        r_txdone    <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_issue) begin
                        r_rd_addr   <= w_rd_last ? 16'd0 : r_rd_addr + 16'd1;
                        r_issue_cnt <= r_issue_cnt + 28'd1;
                        if (r_issue_cnt == r_total - 28'd1) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_final) begin
                        r_txdone <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
